// File: rtl/bus_cycle_ctrl.sv
// Bus cycle controller: runs T1-T4 multiplexed bus cycles with wait states,
// arbitrates execution-unit requests over prefetch, and pushes fetched bytes.
module bus_cycle_ctrl #(
    parameter int unsigned QUEUE_BYTES = 4,
    parameter int unsigned WAIT_LIMIT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_error,
    input  logic [19:0] fetch_addr,
    input  logic [2:0]  queue_count,
    input  logic        flush,
    output logic        queue_wr,
    output logic [7:0]  queue_data,
    output logic        ip_inc,
    output logic [19:0] addr_out,
    output logic        ale,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    input  logic [7:0]  ad_in,
    output logic        rd_wr,
    input  logic        ready
);

    localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_TW   = 3'd4,
        S_T4   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            is_write_q, is_write_d;
    logic            is_fetch_q, is_fetch_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            discard_q, discard_d;
    logic [19:0]     addr_out_q, addr_out_d;
    logic [7:0]      ad_out_q, ad_out_d;
    logic            ad_oe_q, ad_oe_d;
    logic            rd_wr_q, rd_wr_d;
    logic            ale_q, ale_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_rdata_q, rsp_rdata_d;
    logic            rsp_error_q, rsp_error_d;
    logic            queue_wr_q, queue_wr_d;
    logic [7:0]      queue_data_q, queue_data_d;
    logic            ip_inc_q, ip_inc_d;

    logic            start;
    logic            start_write;
    logic            start_fetch;
    logic [19:0]     start_addr;
    logic            finish;
    logic            timeout;
    logic            drop;
    logic [7:0]      rx_byte;

    // Next-state and registered-output computation for the bus cycle sequencer
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        is_write_d   = is_write_q;
        is_fetch_d   = is_fetch_q;
        wdata_d      = wdata_q;
        discard_d    = discard_q;
        addr_out_d   = addr_out_q;
        ad_out_d     = ad_out_q;
        ad_oe_d      = ad_oe_q;
        rd_wr_d      = rd_wr_q;
        ale_d        = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_error_d  = 1'b0;
        queue_wr_d   = 1'b0;
        queue_data_d = queue_data_q;
        ip_inc_d     = 1'b0;
        req_ready    = 1'b0;
        start        = 1'b0;
        start_write  = 1'b0;
        start_fetch  = 1'b0;
        start_addr   = fetch_addr;
        finish       = 1'b0;
        timeout      = 1'b0;
        drop         = discard_q | flush;
        rx_byte      = 8'h00;

        // a flush anywhere inside a prefetch cycle poisons its byte
        if (is_fetch_q && flush && state_q != S_IDLE) begin
            discard_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    req_ready   = ~reset;
                    start       = 1'b1;
                    start_write = req_write;
                    start_addr  = req_addr;
                    wdata_d     = req_wdata;
                end else if (32'(queue_count) < QUEUE_BYTES && !flush) begin
                    start       = 1'b1;
                    start_fetch = 1'b1;
                end
            end
            S_T1: begin
                state_d = S_T2;
                ad_oe_d = is_write_q;
                if (is_write_q) begin
                    ad_out_d = wdata_q;
                end
            end
            S_T2: begin
                state_d = S_T3;
            end
            S_T3, S_TW: begin
                if (ready) begin
                    finish = 1'b1;
                end else if (wait_cnt_q == CW'(WAIT_LIMIT)) begin
                    finish  = 1'b1;
                    timeout = 1'b1;
                end else begin
                    state_d    = S_TW;
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            S_T4: begin
                state_d    = S_IDLE;
                wait_cnt_d = '0;
                discard_d  = 1'b0;
                ad_oe_d    = 1'b0;
                rd_wr_d    = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start) begin
            state_d    = S_T1;
            is_write_d = start_write;
            is_fetch_d = start_fetch;
            discard_d  = 1'b0;
            addr_out_d = start_addr;
            ad_out_d   = start_addr[7:0];
            ad_oe_d    = 1'b1;
            ale_d      = 1'b1;
            rd_wr_d    = ~start_write;
        end

        if (finish) begin
            state_d = S_T4;
            ad_oe_d = 1'b0;
            rx_byte = (timeout || is_write_q) ? 8'h00 : ad_in;
            if (!is_fetch_q) begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = rx_byte;
                rsp_error_d = timeout;
            end else if (!timeout && !drop) begin
                queue_wr_d   = 1'b1;
                ip_inc_d     = 1'b1;
                queue_data_d = rx_byte;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            is_write_q   <= 1'b0;
            is_fetch_q   <= 1'b0;
            wdata_q      <= 8'h00;
            discard_q    <= 1'b0;
            addr_out_q   <= 20'h00000;
            ad_out_q     <= 8'h00;
            ad_oe_q      <= 1'b0;
            rd_wr_q      <= 1'b1;
            ale_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 8'h00;
            rsp_error_q  <= 1'b0;
            queue_wr_q   <= 1'b0;
            queue_data_q <= 8'h00;
            ip_inc_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            is_write_q   <= is_write_d;
            is_fetch_q   <= is_fetch_d;
            wdata_q      <= wdata_d;
            discard_q    <= discard_d;
            addr_out_q   <= addr_out_d;
            ad_out_q     <= ad_out_d;
            ad_oe_q      <= ad_oe_d;
            rd_wr_q      <= rd_wr_d;
            ale_q        <= ale_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_error_q  <= rsp_error_d;
            queue_wr_q   <= queue_wr_d;
            queue_data_q <= queue_data_d;
            ip_inc_q     <= ip_inc_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_error  = rsp_error_q;
    assign queue_wr   = queue_wr_q;
    assign queue_data = queue_data_q;
    assign ip_inc     = ip_inc_q;
    assign addr_out   = addr_out_q;
    assign ale        = ale_q;
    assign ad_out     = ad_out_q;
    assign ad_oe      = ad_oe_q;
    assign rd_wr      = rd_wr_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: transaction-age reference model,
// directed scenarios with literal pins, then randomized traffic.
module tb_bus_cycle_ctrl;

    localparam int unsigned QB = 4;
    localparam int unsigned WL = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_error;
    logic [19:0] fetch_addr;
    logic [2:0]  queue_count;
    logic        flush;
    logic        queue_wr;
    logic [7:0]  queue_data;
    logic        ip_inc;
    logic [19:0] addr_out;
    logic        ale;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic [7:0]  ad_in;
    logic        rd_wr;
    logic        ready;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int pushes = 0;

    // reference model: a bus cycle is tracked only by its age since acceptance
    bit          m_busy = 1'b0;
    bit          m_fetch, m_write, m_disc, m_final;
    int unsigned m_age;
    logic [7:0]  m_wdata;

    bit          e_ale, e_ad_oe, e_rd_wr, e_rsp_valid, e_rsp_error, e_queue_wr, e_ip_inc;
    logic [19:0] e_addr_out;
    logic [7:0]  e_ad_out, e_rsp_rdata, e_queue_data;

    bus_cycle_ctrl #(.QUEUE_BYTES(QB), .WAIT_LIMIT(WL)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .fetch_addr (fetch_addr),
        .queue_count(queue_count),
        .flush      (flush),
        .queue_wr   (queue_wr),
        .queue_data (queue_data),
        .ip_inc     (ip_inc),
        .addr_out   (addr_out),
        .ale        (ale),
        .ad_out     (ad_out),
        .ad_oe      (ad_oe),
        .ad_in      (ad_in),
        .rd_wr      (rd_wr),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_start(input bit fetch, input bit wr, input logic [19:0] a,
                               input logic [7:0] wd);
        m_busy     = 1'b1;
        m_fetch    = fetch;
        m_write    = wr;
        m_wdata    = wd;
        m_age      = 1;
        m_final    = 1'b0;
        m_disc     = 1'b0;
        e_ale      = 1'b1;
        e_ad_oe    = 1'b1;
        e_ad_out   = a[7:0];
        e_addr_out = a;
        e_rd_wr    = !wr;
    endtask

    // what the registered outputs must be after the coming edge
    task automatic model_step();
        bit         tmo;
        logic [7:0] b;
        e_ale       = 1'b0;
        e_rsp_valid = 1'b0;
        e_rsp_error = 1'b0;
        e_queue_wr  = 1'b0;
        e_ip_inc    = 1'b0;
        if (reset) begin
            m_busy       = 1'b0;
            e_ad_oe      = 1'b0;
            e_rd_wr      = 1'b1;
            e_ad_out     = 8'h00;
            e_addr_out   = 20'h00000;
            e_rsp_rdata  = 8'h00;
            e_queue_data = 8'h00;
        end else if (!m_busy) begin
            if (req_valid)
                model_start(1'b0, req_write, req_addr, req_wdata);
            else if (int'(queue_count) < int'(QB) && !flush)
                model_start(1'b1, 1'b0, fetch_addr, 8'h00);
        end else if (m_final) begin
            m_busy  = 1'b0;
            e_ad_oe = 1'b0;
            e_rd_wr = 1'b1;
        end else begin
            if (m_fetch && flush) m_disc = 1'b1;
            if (m_age == 1) begin
                e_ad_oe = m_write;
                if (m_write) e_ad_out = m_wdata;
            end else if (m_age >= 3 && (ready || m_age == 3 + WL)) begin
                tmo     = !ready;
                b       = (tmo || m_write) ? 8'h00 : ad_in;
                m_final = 1'b1;
                e_ad_oe = 1'b0;
                if (!m_fetch) begin
                    e_rsp_valid = 1'b1;
                    e_rsp_rdata = b;
                    e_rsp_error = tmo;
                end else if (!tmo && !m_disc) begin
                    e_queue_wr   = 1'b1;
                    e_ip_inc     = 1'b1;
                    e_queue_data = b;
                end
            end
            m_age++;
        end
    endtask

    task automatic compare();
        chk("ale",       32'(ale),       32'(e_ale));
        chk("ad_oe",     32'(ad_oe),     32'(e_ad_oe));
        chk("rd_wr",     32'(rd_wr),     32'(e_rd_wr));
        chk("addr_out",  32'(addr_out),  32'(e_addr_out));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
        chk("queue_wr",  32'(queue_wr),  32'(e_queue_wr));
        chk("ip_inc",    32'(ip_inc),    32'(e_ip_inc));
        if (e_ad_oe) chk("ad_out", 32'(ad_out), 32'(e_ad_out));
        if (e_rsp_valid) begin
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rsp_rdata));
            chk("rsp_error", 32'(rsp_error), 32'(e_rsp_error));
        end
        if (e_queue_wr) chk("queue_data", 32'(queue_data), 32'(e_queue_data));
        if (queue_wr) pushes++;
    endtask

    // one clock: check combinational accept, advance model, compare after edge
    task automatic step();
        #1;
        chk("req_ready", 32'(req_ready), 32'(!reset && !m_busy && req_valid));
        model_step();
        @(posedge clk);
        cyc++;
        #1;
        compare();
    endtask

    task automatic quiet();
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        flush       = 1'b0;
        ready       = 1'b1;
        queue_count = 3'd4;
    endtask

    initial begin
        int n;
        quiet();
        reset      = 1'b1;
        req_addr   = 20'h0;
        req_wdata  = 8'h00;
        fetch_addr = 20'h0;
        ad_in      = 8'h00;
        step();
        step();
        chk("rst_ad_oe",     32'(ad_oe),     32'd0);
        chk("rst_rd_wr",     32'(rd_wr),     32'd1);
        chk("rst_addr_out",  32'(addr_out),  32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_queue_wr",  32'(queue_wr),  32'd0);
        quiet();

        // zero-wait read
        req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h12345; ad_in = 8'hA5;
        step();
        chk("zw_ale",    32'(ale),    32'd1);
        chk("zw_ad_out", 32'(ad_out), 32'h45);
        req_valid = 1'b0;
        step(); step(); step();
        chk("zw_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("zw_rdata",     32'(rsp_rdata), 32'hA5);
        chk("zw_error",     32'(rsp_error), 32'd0);
        step();

        // write with two wait states
        req_valid = 1'b1; req_write = 1'b1; req_addr = 20'hABCDE; req_wdata = 8'h3C; ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        chk("wr_ad_out_t2", 32'(ad_out), 32'h3C);
        chk("wr_rd_wr_t2",  32'(rd_wr),  32'd0);
        step(); step(); step();
        chk("wr_no_rsp_yet", 32'(rsp_valid), 32'd0);
        ready = 1'b1;
        step();
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rd_wr_t4",  32'(rd_wr),     32'd0);
        chk("wr_rdata",     32'(rsp_rdata), 32'd0);
        step();

        // prefetch fill until the queue is full
        fetch_addr = 20'h00100; queue_count = 3'd0; pushes = 0;
        for (int i = 0; i < 30; i++) begin
            ad_in = 8'(i * 7 + 1);
            step();
            if (e_queue_wr) queue_count = 3'(queue_count + 3'd1);
        end
        chk("fill_pushes", 32'(pushes),      32'd4);
        chk("fill_qcount", 32'(queue_count), 32'd4);

        // exec request arriving mid-fetch waits for the fetch, then wins
        queue_count = 3'd0; ad_in = 8'h11;
        step(); step();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h55555;
        step();
        chk("pri_busy_rr", 32'(req_ready), 32'd0);
        step();
        chk("pri_fetch_push", 32'(queue_wr), 32'd1);
        ad_in = 8'h99;
        step();
        chk("pri_rr", 32'(req_ready), 32'd1);
        step();
        chk("pri_exec_addr", 32'(addr_out), 32'h55555);
        req_valid = 1'b0; queue_count = 3'd4;
        step(); step(); step();
        chk("pri_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("pri_rdata",     32'(rsp_rdata), 32'h99);
        step();

        // flush during T3 drops the byte; the next fetch proceeds normally
        queue_count = 3'd3; ad_in = 8'h5A;
        step(); step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_t4_qwr",   32'(queue_wr), 32'd0);
        chk("fl_t4_ipinc", 32'(ip_inc),   32'd0);
        step();
        step();
        chk("fl_refetch_ale", 32'(ale), 32'd1);
        step(); step(); step();
        chk("fl_refetch_push", 32'(queue_wr),   32'd1);
        chk("fl_refetch_data", 32'(queue_data), 32'h5A);
        step();
        queue_count = 3'd4;

        // wait-state timeout on an exec read
        req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h0F0F0; ready = 1'b0; ad_in = 8'h77;
        step();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
        chk("to_steps", 32'(n),         32'd19);
        chk("to_error", 32'(rsp_error), 32'd1);
        chk("to_rdata", 32'(rsp_rdata), 32'd0);
        ready = 1'b1;
        step();

        // reset while in a wait state
        req_valid = 1'b1; ready = 1'b0;
        step();
        req_valid = 1'b0;
        step(); step(); step(); step();
        reset = 1'b1;
        step();
        chk("rs_ad_oe",     32'(ad_oe),     32'd0);
        chk("rs_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rs_rd_wr",     32'(rd_wr),     32'd1);
        quiet();
        step(); step();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            req_valid  = ($urandom_range(0, 3) == 0);
            req_write  = 1'($urandom_range(0, 1));
            req_addr   = 20'($urandom);
            req_wdata  = 8'($urandom);
            fetch_addr = 20'($urandom);
            flush      = ($urandom_range(0, 9) == 0);
            ad_in      = 8'($urandom);
            if ((i % 1000) < 150) ready = ($urandom_range(0, 24) == 0);
            else                  ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) queue_count = 3'($urandom_range(0, 4));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
